// File: rtl/add_pkg.sv
// Shared constants for the slice-serial adder.
// FSM state encoding and index-width helper.
package add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_seq_if.sv
// Operand/result handshake bundle for add_seq.
// master = producer/consumer side, slave = adder.
interface add_seq_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ov;

  modport master (
    output in_valid, a, b, ci, out_ready,
    input  in_ready, out_valid, s, co, ov
  );

  modport slave (
    input  in_valid, a, b, ci, out_ready,
    output in_ready, out_valid, s, co, ov
  );

endinterface

// File: rtl/add_slice.sv
// One SLICE-bit ripple step with carry in/out.
// The only adder in the design.
module add_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co
);

  // Slice sum with carry out in the extra bit
  always_comb begin
    {co, s} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, ci};
  end

endmodule

// File: rtl/add_seq.sv
// Multi-cycle adder: SLICE bits per clock, NSLICE cycles.
// Results held in DONE until the consumer takes them.
module add_seq
  import add_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic        clk,
  input logic        rst,
  add_seq_if.slave   bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW = idx_w(NSLICE);
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  if ((WIDTH % SLICE) != 0) begin : g_bad_slice
    $error("add_seq: WIDTH must be a multiple of SLICE");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             cy_q, cy_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;
  logic             ovld_q, ovld_d;
  logic             ird_q, ird_d;

  int               base;
  logic [SLICE-1:0] sl_a, sl_b, sl_s;
  logic             sl_co;

  // Select the current operand slices
  always_comb begin
    base = int'(idx_q) * SLICE;
    sl_a = a_q[base +: SLICE];
    sl_b = b_q[base +: SLICE];
  end

  add_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .ci (cy_q),
    .s  (sl_s),
    .co (sl_co)
  );

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    co_d    = co_q;
    ov_d    = ov_q;
    ovld_d  = ovld_q;
    ird_d   = ird_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          cy_d    = bus.ci;
          idx_d   = '0;
          sum_d   = '0;
          ird_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[base +: SLICE] = sl_s;
        cy_d = sl_co;
        if (idx_q == LAST) begin
          co_d    = sl_co;
          ov_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (sl_s[SLICE-1] != a_q[WIDTH-1]);
          ovld_d  = 1'b1;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          ovld_d  = 1'b0;
          ird_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ird_d   = 1'b1;
        ovld_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      ovld_q  <= 1'b0;
      ird_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
      ovld_q  <= ovld_d;
      ird_q   <= ird_d;
    end
  end

  assign bus.in_ready  = ird_q;
  assign bus.out_valid = ovld_q;
  assign bus.s         = sum_q;
  assign bus.co        = co_q;
  assign bus.ov        = ov_q;

endmodule
